// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers for the round controller.
package aes_pkg;

   localparam int unsigned AES_NB        = 4;
   localparam int unsigned AES128_ROUNDS = 10;

   // FIPS byte k lives at bits [8k+7:8k]; byte k is row k%4, column k/4.
   typedef logic [127:0] aes_block_t;

   typedef enum logic [2:0] {
      IDLE,
      KEY0,
      SUB,
      RND,
      DONE
   } aes_ctrl_state_t;

   // Multiply by x in GF(2^8), reduction polynomial 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r rotates left by r columns.
   function automatic aes_block_t shift_rows(input aes_block_t s);
      aes_block_t o;
      o = '0;
      for (int unsigned r = 0; r < AES_NB; r++) begin
         for (int unsigned c = 0; c < AES_NB; c++) begin
            o[8*(r + AES_NB*c) +: 8] = s[8*(r + AES_NB*((c + r) % AES_NB)) +: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_mix_columns.sv
// Combinational AES MixColumns over all four columns.
// Ports: data_i  state after ShiftRows
//        data_c  mixed state (combinational)
module aes_mix_columns
   import aes_pkg::*;
(
   input  logic [127:0] data_i,
   output logic [127:0] data_c
);

   for (genvar c = 0; c < AES_NB; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;

      assign a0 = data_i[32*c      +: 8];
      assign a1 = data_i[32*c + 8  +: 8];
      assign a2 = data_i[32*c + 16 +: 8];
      assign a3 = data_i[32*c + 24 +: 8];

      // Circulant {02,03,01,01}; 3*a is written as xtime(a)^a.
      assign data_c[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign data_c[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign data_c[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign data_c[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer around an external registered
// SubBytes stage. ShiftRows, MixColumns and AddRoundKey are applied inline.
// Ports: clk_i/rst_i (async active-high reset); in_valid/in_ready/in_data
//        plaintext; out_valid/out_ready/out_data ciphertext; rk_req/rk_idx/
//        rk_valid/rk_data round-key fetch; sb_in/sb_out SubBytes stage;
//        busy; abort_i only when AES_ABORT_EN is defined.
// Config: AES_ABORT_EN adds abort_i, returning to IDLE from any busy state.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
)
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         rk_req,
   output logic [3:0]   rk_idx,
   input  logic         rk_valid,
   input  logic [127:0] rk_data,
   output logic [127:0] sb_in,
   input  logic [127:0] sb_out,
`ifdef AES_ABORT_EN
   input  logic         abort_i,
`endif
   output logic         busy
);

   localparam int unsigned ROUND_W = 4;
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

   aes_ctrl_state_t    state_q, state_d;
   logic [ROUND_W-1:0] round_q, round_d;
   aes_block_t         data_q, data_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               rk_req_q, rk_req_d;
   logic [3:0]         rk_idx_q, rk_idx_d;
   logic               busy_q, busy_d;
   logic               abort;
   aes_block_t         sr_c, mc_c, rnd_c;

`ifdef AES_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   // Round datapath: sb_out is stable during RND because data_q is held.
   assign sr_c = shift_rows(sb_out);

   aes_mix_columns u_mix (
      .data_i (sr_c),
      .data_c (mc_c)
   );

   assign rnd_c = ((round_q == LAST_ROUND) ? sr_c : mc_c) ^ rk_data;

   // Next state, round counter, state register and output decode.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      data_d  = data_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               state_d = KEY0;
            end
         end
         KEY0: begin
            if (rk_valid) begin
               data_d  = data_q ^ rk_data;
               round_d = ROUND_W'(1);
               state_d = SUB;
            end
         end
         SUB: begin
            state_d = RND;
         end
         RND: begin
            if (rk_valid) begin
               data_d = rnd_c;
               if (round_q == LAST_ROUND) begin
                  state_d = DONE;
               end else begin
                  round_d = round_q + ROUND_W'(1);
                  state_d = SUB;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over key and sink handshakes and discards the block.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         round_d = '0;
         data_d  = '0;
      end

      // Outputs are registered from the next state so they track state_q.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      rk_req_d    = (state_d == KEY0) || (state_d == RND);
      busy_d      = (state_d == KEY0) || (state_d == SUB) || (state_d == RND);
      rk_idx_d    = (state_d == RND) ? round_d : 4'd0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         round_q     <= '0;
         data_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         rk_req_q    <= 1'b0;
         rk_idx_q    <= 4'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         data_q      <= data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         rk_req_q    <= rk_req_d;
         rk_idx_q    <= rk_idx_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign rk_req    = rk_req_q;
   assign rk_idx    = rk_idx_q;
   assign busy      = busy_q;
   assign out_data  = data_q;
   assign sb_in     = data_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: models the registered SubBytes
// stage and a stalling key-schedule port, and compares against a byte-array
// AES-128 reference model plus FIPS-197 known answers.
// Define AES_ABORT_EN to also exercise abort_i.
module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         rk_req;
   logic [3:0]   rk_idx;
   logic         rk_valid = 1'b0;
   logic [127:0] rk_data = '0;
   logic [127:0] sb_in;
   logic [127:0] sb_out;
   logic         busy;
`ifdef AES_ABORT_EN
   logic         abort_i = 1'b0;
`endif

   int n_err = 0;
   int n_chk = 0;

   logic [7:0]   sbox_t [256];
   logic [127:0] rk_tab [11];
   int           stall_max = 0;
   int           idx_log [$];

   always #5 clk = ~clk;

   aes_round_ctrl dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .rk_req    (rk_req),
      .rk_idx    (rk_idx),
      .rk_valid  (rk_valid),
      .rk_data   (rk_data),
      .sb_in     (sb_in),
      .sb_out    (sb_out),
`ifdef AES_ABORT_EN
      .abort_i   (abort_i),
`endif
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // Textbook hex strings list byte 0 first; the bus puts byte 0 at bits [7:0].
   function automatic logic [127:0] fips(input logic [127:0] h);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = h[8*(15-k) +: 8];
      return o;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [7:0] w [44][4];
      logic [7:0] tmp [4];
      logic [7:0] rc = 8'h01;
      logic [7:0] x;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i + j) +: 8];
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
         if (i % 4 == 0) begin
            x      = tmp[0];
            tmp[0] = sbox_t[tmp[1]] ^ rc;
            tmp[1] = sbox_t[tmp[2]];
            tmp[2] = sbox_t[tmp[3]];
            tmp[3] = sbox_t[x];
            rc     = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
      end
      for (int r = 0; r < 11; r++)
         for (int k = 0; k < 16; k++) rk_tab[r][8*k +: 8] = w[4*r + k/4][k%4];
   endtask

   // Reference AES-128 encryption using the current rk_tab.
   function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] o;
      for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ rk_tab[0][8*k +: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++) t[row + 4*col] = s[row + 4*((col + row) % 4)];
         for (int col = 0; col < 4; col++) begin
            a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
            if (r < 10) begin
               s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
            end
         end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_tab[r][8*k +: 8];
      end
      for (int k = 0; k < 16; k++) o[8*k +: 8] = s[k];
      return o;
   endfunction

   // External SubBytes stage: registered, synchronous reset.
   always @(posedge clk) begin
      if (rst) sb_out <= '0;
      else for (int k = 0; k < 16; k++) sb_out[8*k +: 8] <= sbox_t[sb_in[8*k +: 8]];
   end

   // Key-schedule port with random stalls; also checks request stability.
   int         kp_stall = 0;
   bit         kp_need = 1'b1;
   bit         kp_prev_req = 1'b0;
   logic [3:0] kp_prev_idx = 4'd0;

   always @(negedge clk) begin
      if (rst) begin
         rk_valid    = 1'b0;
         kp_need     = 1'b1;
         kp_prev_req = 1'b0;
      end else begin
         if (kp_prev_req && !rk_valid) begin
            check("rk_req_hold", 128'(rk_req), 128'(1));
            check("rk_idx_hold", 128'(rk_idx), 128'(kp_prev_idx));
         end
         kp_prev_req = rk_req;
         kp_prev_idx = rk_idx;
         if (!rk_req) begin
            kp_need  = 1'b1;
            rk_valid = 1'($urandom_range(0, 1));
            rk_data  = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            if (kp_need) begin
               kp_stall = $urandom_range(0, stall_max);
               kp_need  = 1'b0;
            end
            if (kp_stall > 0) begin
               kp_stall--;
               rk_valid = 1'b0;
               rk_data  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               rk_valid = 1'b1;
               rk_data  = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;
               idx_log.push_back(int'(rk_idx));
            end
         end
      end
   end

   // Runs one block starting at a negedge with the DUT idle; ends at the
   // negedge after the output handshake, so calls chain back-to-back.
   task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input int max_stall, input int hold,
                            input int exp_lat, input bit chk_idx);
      int n = 0;
      bit got = 1'b0;
      expand_key(key);
      stall_max = max_stall;
      idx_log.delete();
      check({tag, "_idle_rdy"}, 128'(in_ready), 128'(1));
      in_valid  = 1'b1;
      in_data   = pt;
      out_ready = (hold == 0);
      while (n < 400 && !got) begin
         @(negedge clk);
         n++;
         in_valid = 1'b0;
         if (out_valid) got = 1'b1;
      end
      if (!got) begin
         check({tag, "_timeout"}, 128'(0), 128'(1));
         out_ready = 1'b1;
         return;
      end
      if (exp_lat > 0) check({tag, "_latency"}, 128'(n), 128'(exp_lat));
      check({tag, "_ct"}, out_data, exp);
      if (chk_idx) begin
         check({tag, "_idx_cnt"}, 128'(idx_log.size()), 128'(11));
         for (int i = 0; i < idx_log.size() && i < 11; i++)
            check({tag, "_idx_seq"}, 128'(idx_log[i]), 128'(i));
      end
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check({tag, "_hold_ov"}, 128'(out_valid), 128'(1));
         check({tag, "_hold_data"}, out_data, exp);
         check({tag, "_hold_rdy"}, 128'(in_ready), 128'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_post_ov"}, 128'(out_valid), 128'(0));
      check({tag, "_post_rdy"}, 128'(in_ready), 128'(1));
   endtask

   // Presents a block and waits for the given RND round index.
   task automatic start_until_round(input string tag, input logic [127:0] pt,
                                    input logic [127:0] key, input logic [3:0] rnd);
      int n = 0;
      bit hit = 1'b0;
      expand_key(key);
      stall_max = 0;
      in_valid  = 1'b1;
      in_data   = pt;
      while (n < 200 && !hit) begin
         @(negedge clk);
         n++;
         in_valid = 1'b0;
         if (rk_req && rk_idx == rnd) hit = 1'b1;
      end
      if (!hit) check({tag, "_reach"}, 128'(0), 128'(1));
   endtask

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   initial begin
      logic [127:0] rpt, rkey, rexp;
      build_sbox();
      #1 rst = 1'b1;
      #1;
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_rk_req", 128'(rk_req), 128'(0));
      check("rst_rk_idx", 128'(rk_idx), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_out_data", out_data, 128'(0));
      check("rst_sb_in", sb_in, 128'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_block("appb", fips(PT_B), fips(KEY_B), fips(CT_B), 0, 0, 22, 1'b1);
      run_block("appc_stall", fips(PT_C), fips(KEY_C), fips(CT_C), 5, 0, 0, 1'b1);
      run_block("appb_bp", fips(PT_B), fips(KEY_B), fips(CT_B), 0, 7, 0, 1'b0);
      run_block("b2b_c", fips(PT_C), fips(KEY_C), fips(CT_C), 2, 0, 0, 1'b0);
      run_block("b2b_b", fips(PT_B), fips(KEY_B), fips(CT_B), 2, 0, 0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         rpt  = {$urandom, $urandom, $urandom, $urandom};
         rkey = {$urandom, $urandom, $urandom, $urandom};
         expand_key(rkey);
         rexp = model_encrypt(rpt);
         run_block("rand", rpt, rkey, rexp, 3, (i == 2) ? 3 : 0, 0, 1'b1);
      end

      // Asynchronous reset while waiting in round 5.
      start_until_round("rst5", fips(PT_B), fips(KEY_B), 4'd5);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 128'(out_valid), 128'(0));
      check("arst_in_ready", 128'(in_ready), 128'(1));
      check("arst_rk_req", 128'(rk_req), 128'(0));
      check("arst_busy", 128'(busy), 128'(0));
      check("arst_out_data", out_data, 128'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_block("after_rst", fips(PT_B), fips(KEY_B), fips(CT_B), 0, 0, 22, 1'b0);

`ifdef AES_ABORT_EN
      begin
         bit seen_ov = 1'b0;
         start_until_round("abort3", fips(PT_C), fips(KEY_C), 4'd3);
         #1;
         abort_i  = 1'b1;
         rk_valid = 1'b1;
         rk_data  = rk_tab[3];
         @(negedge clk);
         abort_i = 1'b0;
         check("abort_busy", 128'(busy), 128'(0));
         check("abort_in_ready", 128'(in_ready), 128'(1));
         check("abort_rk_req", 128'(rk_req), 128'(0));
         check("abort_out_data", out_data, 128'(0));
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1'b1;
         end
         check("abort_no_ov", 128'(seen_ov), 128'(0));
         run_block("after_abort", fips(PT_C), fips(KEY_C), fips(CT_C), 3, 0, 0, 1'b1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
